// File: rtl/register_file.sv
// rtl/register_file.sv - 8x16 register file, two combinational read ports with write-through bypass
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p5,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  wr_fire;

    // A write is committed only outside reset; the same term gates the bypass.
    assign wr_fire = reset & p5 & write_enable;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[write_addr] <= write_data;
        end
    end

    always_comb begin
        data_a = regs_q[read_addr_a];
        data_b = regs_q[read_addr_b];
        if (wr_fire && (write_addr == read_addr_a)) begin
            data_a = write_data;
        end
        if (wr_fire && (write_addr == read_addr_b)) begin
            data_b = write_data;
        end
    end

endmodule
